// File: rtl/mac_operand_loader.sv
// Streams B rows one beat per cycle with a 16-row A group that swaps on group boundaries.
// Optional OPERAND_LOADER_BASE_ADDR_EN: honour a_base/b_base, otherwise both bases are 0.
module mac_operand_loader #(
  parameter int ROW_W  = 264,
  parameter int A_ROWS = 16,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-4:0]       n_groups,
  input  logic [ADDR_W-1:0]       a_base,
  input  logic [ADDR_W-1:0]       b_base,
  output logic                    a_sram_ren,
  output logic [ADDR_W-1:0]       a_sram_addr,
  input  logic [ROW_W-1:0]        a_sram_rdata,
  output logic                    b_sram_ren,
  output logic [ADDR_W-1:0]       b_sram_addr,
  input  logic [ROW_W-1:0]        b_sram_rdata,
  output logic [ROW_W*A_ROWS-1:0] a_vec,
  output logic [ROW_W-1:0]        b_vec,
  output logic                    valid,
  output logic                    busy,
  output logic                    done
);

  localparam int CW         = ADDR_W + 1;
  localparam int GW         = ADDR_W - 3;
  localparam int SW         = $clog2(A_ROWS);
  localparam int MAX_GROUPS = 1 << (ADDR_W - 4);

  typedef enum logic [2:0] {IDLE, PRELOAD, STREAM, DRAIN, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [GW-1:0]     ng_q;
  logic [ADDR_W-1:0] a_base_q, b_base_q;
  logic [SW-1:0]     a_slot_q, a_ret_slot;
  logic              a_ret, b_ret, b_first_q, b_ret_first;
  logic [ROW_W-1:0]  shadow [A_ROWS];

  logic [GW-1:0]     ng_sat;
  logic [CW-1:0]     beats;
  logic              next_grp;
  logic [ADDR_W-1:0] a_base_start, b_base_start;

`ifdef OPERAND_LOADER_BASE_ADDR_EN
  assign a_base_start = a_base;
  assign b_base_start = b_base;
`else
  logic unused_bases;
  assign unused_bases = ^{a_base, b_base};
  assign a_base_start = '0;
  assign b_base_start = '0;
`endif

  assign ng_sat   = (n_groups > GW'(MAX_GROUPS)) ? GW'(MAX_GROUPS) : n_groups;
  assign beats    = CW'(ng_q) << SW;
  assign next_grp = ((cnt >> SW) + CW'(1)) < CW'(ng_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      ng_q        <= '0;
      a_base_q    <= '0;
      b_base_q    <= '0;
      a_slot_q    <= '0;
      a_ret_slot  <= '0;
      a_ret       <= 1'b0;
      b_ret       <= 1'b0;
      b_first_q   <= 1'b0;
      b_ret_first <= 1'b0;
      a_sram_ren  <= 1'b0;
      a_sram_addr <= '0;
      b_sram_ren  <= 1'b0;
      b_sram_addr <= '0;
      a_vec       <= '0;
      b_vec       <= '0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      for (int unsigned i = 0; i < A_ROWS; i++) shadow[i] <= '0;
    end else begin
      // Read-return pipeline: flags follow the enables by one cycle, matching SRAM latency.
      a_ret       <= a_sram_ren;
      a_ret_slot  <= a_slot_q;
      b_ret       <= b_sram_ren;
      b_ret_first <= b_first_q;
      valid       <= b_ret;
      done        <= 1'b0;

      if (a_ret) shadow[a_ret_slot] <= a_sram_rdata;
      // Swap reads pre-edge shadow, so a same-edge shadow write lands in the next group.
      if (b_ret) begin
        b_vec <= b_sram_rdata;
        if (b_ret_first)
          for (int unsigned i = 0; i < A_ROWS; i++)
            a_vec[ROW_W*(A_ROWS-1-i) +: ROW_W] <= shadow[i];
      end

      unique case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            a_base_q <= a_base_start;
            b_base_q <= b_base_start;
            ng_q     <= ng_sat;
            if (ng_sat == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= PRELOAD;
              busy        <= 1'b1;
              a_sram_ren  <= 1'b1;
              a_sram_addr <= a_base_start;
              a_slot_q    <= '0;
              cnt         <= CW'(1);
            end
          end
        end
        PRELOAD: begin
          if (cnt == CW'(A_ROWS)) begin
            state       <= STREAM;
            b_sram_ren  <= 1'b1;
            b_sram_addr <= b_base_q;
            b_first_q   <= 1'b1;
            a_sram_ren  <= (ng_q > GW'(1));
            a_sram_addr <= a_base_q + ADDR_W'(A_ROWS);
            a_slot_q    <= '0;
            cnt         <= CW'(1);
          end else begin
            a_sram_addr <= a_base_q + ADDR_W'(cnt);
            a_slot_q    <= cnt[SW-1:0];
            cnt         <= cnt + CW'(1);
          end
        end
        STREAM: begin
          if (cnt == beats) begin
            state      <= DRAIN;
            a_sram_ren <= 1'b0;
            b_sram_ren <= 1'b0;
            b_first_q  <= 1'b0;
            cnt        <= '0;
          end else begin
            b_sram_addr <= b_base_q + ADDR_W'(cnt);
            b_first_q   <= (cnt[SW-1:0] == '0);
            a_sram_ren  <= next_grp;
            a_sram_addr <= a_base_q + ADDR_W'(cnt) + ADDR_W'(A_ROWS);
            a_slot_q    <= cnt[SW-1:0];
            cnt         <= cnt + CW'(1);
          end
        end
        DRAIN: begin
          if (cnt == CW'(1)) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mac_operand_loader.md
# mac_operand_loader

Upstream operand feeder for `mac_16`. On a `start` pulse it reads A-matrix rows and B-matrix rows from two single-port synchronous SRAMs. It presents one 264-bit `b_vec` beat per cycle with `valid`, and a 16-row packed `a_vec` that changes at every 16-beat group boundary. A shadow buffer prefetches the next A group while the current group streams, so the stream has no gaps between groups.

## Interface
- `ROW_W`, 264: bits per SRAM row (one operand vector).
- `A_ROWS`, 16: A rows packed per `a_vec`; also the group length in beats.
- `ADDR_W`, 5: SRAM address width. Maximum rows is 2^ADDR_W.
- `clk` input 1: the single clock. All logic updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle launch pulse. Ignored while `busy`=1.
- `n_groups` input ADDR_W-3: number of 16-beat groups to stream.
- `a_base` input ADDR_W: A start row, sampled on `start`. Used only with the macro.
- `b_base` input ADDR_W: B start row, sampled on `start`. Used only with the macro.
- `a_sram_ren` output 1: read enable for the A SRAM.
- `a_sram_addr` output ADDR_W: read address for the A SRAM.
- `a_sram_rdata` input ROW_W: A read data, valid in the cycle after the address is sampled.
- `b_sram_ren` output 1: read enable for the B SRAM.
- `b_sram_addr` output ADDR_W: read address for the B SRAM.
- `b_sram_rdata` input ROW_W: B read data, same 1-cycle latency as A.
- `a_vec` output ROW_W*A_ROWS: current A group.
- `b_vec` output ROW_W: current B beat.
- `valid` output 1: `b_vec`/`a_vec` hold a live beat. Drives `mac_16.valid`.
- `busy` output 1: high from the cycle after `start` until `done`.
- `done` output 1: one-cycle pulse after the last beat.

## Operation
- **Reset values:** all outputs 0; FSM in IDLE; shadow buffer and counters cleared.
- **Reset mid-operation:** abort immediately; `valid`, `ren` and `done` go low asynchronously. No completion is reported afterwards.
- **Beat count:** N = 16·n_groups.
  - `n_groups`=0 on `start`: go straight to DONE. Exactly one `done` pulse, no `valid`, no SRAM reads.
  - `n_groups` above 2^(ADDR_W-4): saturate to 2^(ADDR_W-4).
- **Address arithmetic:** modulo 2^ADDR_W. Base plus offset wraps silently.
- **`a_vec` packing:** for group g, row 16g+0 sits in the MSBs [ROW_W·16-1 : ROW_W·15]; row 16g+15 sits in [ROW_W-1:0].
- **FSM states:**
  - IDLE → PRELOAD on an accepted `start`.
  - PRELOAD (16 cycles): `a_sram_ren`=1, `a_sram_addr` = a_base+0..15. Each returning row is written into shadow slot p. Then → STREAM.
  - STREAM (N cycles, issue index s=0..N-1):
    - `b_sram_ren`=1, `b_sram_addr` = b_base+s.
    - If group ⌊s/16⌋+1 exists, also `a_sram_ren`=1, `a_sram_addr` = a_base+16(⌊s/16⌋+1)+(s mod 16). The returning row fills the shadow.
    - After N cycles → DRAIN.
  - DRAIN: 2 cycles while the last B data returns and is presented. Then → DONE.
  - DONE: pulse `done` for 1 cycle, drop `busy`. Then → IDLE.
- **Beat presentation:** `b_vec` is registered from `b_sram_rdata` in the cycle the data returns, and `valid` is registered alongside it.
- **A group swap:** on the same edge that registers beat 16g, copy the shadow into `a_vec`.
- **Shadow write/read ordering:** a shadow write and the swap read on the same edge are legal; the swap takes the pre-edge contents.
- **Between runs:** `a_vec` and `b_vec` hold their last values while `valid`=0.

## Timing
- **Cycle numbering:** cycle 0 is the cycle `start` is high.
- **PRELOAD:** A reads in cycles 1..16.
- **STREAM:** B read for beat s issued in cycle 17+s; beat s has `valid`=1 in cycle 19+s.
- **A group g+1:** last row returns in cycle 33+16g and is swapped in at the edge ending cycle 34+16g, exactly as beat 16(g+1) appears.
- **Run end:** last `valid` in cycle 18+N; `done` in cycle 19+N; `busy` high in cycles 1..18+N.
- **Back-to-back:** a new `start` is accepted in the `done` cycle or later.
- **Stream continuity:** `valid` is continuous for N cycles with no bubbles.

## Configuration
- **`OPERAND_LOADER_BASE_ADDR_EN` defined:** `a_base` and `b_base` are sampled on the accepted `start` and offset every read address.
- **Not defined:** both ports are ignored and bases are 0. The port list is identical either way.

## Test plan
- **Nominal run:** SRAM rows = 32 distinct patterns, `n_groups`=2, `start` in cycle 0.
  - `valid` high in cycles 19..50; `b_vec` = B[0..31] in order.
  - `a_vec` = {A0..A15} in cycles 19..34 and {A16..A31} in cycles 35..50.
  - `done` in cycle 51.
- **Zero groups:** `n_groups`=0 → `done` in cycle 1; `valid`, `a_sram_ren` and `b_sram_ren` never rise.
- **Ignored start:** `start` pulsed again in cycle 10 of a run → ignored; exactly 32 beats and one `done`.
- **Reset mid-stream:** `rst_n` low in cycle 25 → all outputs 0 immediately. A fresh `start` then replays from beat 0 with the same cycle offsets.
- **Saturation, macro defined:** `n_groups`=3, a_base=16, b_base=16 → `n_groups` saturates to 2; B reads 16..31 then wrap to 0..15, and `a_vec` group 1 = {A0..A15}.
- **Back-to-back runs:** two runs of `n_groups`=1, second `start` in the first run's `done` cycle (35) → second run's `valid` in cycles 54..69, with no stale shadow data.
